// File: rtl/jk_div_sequencer.sv
`default_nettype none
// ============================================================================
// jk_div_sequencer : drives a bank of J-K stages as a programmable modulo-N
//                    counter, with divided clock, TC strobe and feedback check
// Revision: 1.0
// ============================================================================
module jk_div_sequencer #(
   parameter int W         = 3,
   parameter int N_DEFAULT = 3
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         en,
   input  logic         restart,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_n,
   output logic         cfg_ready,
   input  logic [W-1:0] q_fb,
   output logic [W-1:0] j_o,
   output logic [W-1:0] k_o,
   output logic         ff_clr_n,
   output logic         div_o,
   output logic         tc_o,
   output logic         err_o
);

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      HOLD  = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam logic [W-1:0] c_tc_default = W'(N_DEFAULT - 1);
   localparam logic [W-1:0] c_one        = W'(1);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_tc;
   logic [W-1:0] r_exp;
   logic [W-1:0] w_nxt;
   logic [W-1:0] w_j_run;
   logic [W-1:0] w_k_run;

   // Each stage only ever gets set or reset toward the next count, never toggled
   generate
      for (genvar i = 0; i < W; i++) begin : g_stage
         assign w_j_run[i] =  w_nxt[i] & ~q_fb[i];
         assign w_k_run[i] = ~w_nxt[i] &  q_fb[i];
      end
   endgenerate

   always_comb begin
      w_nxt       = (q_fb >= r_tc) ? '0 : q_fb + c_one;
      j_o         = '0;
      k_o         = '0;
      ff_clr_n    = 1'b1;
      cfg_ready   = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         CLEAR: begin
            ff_clr_n    = 1'b0;
            w_state_nxt = HOLD;
         end
         HOLD: begin
            cfg_ready = 1'b1;
            if (en) w_state_nxt = RUN;
         end
         RUN: begin
            j_o       = w_j_run;
            k_o       = w_k_run;
            cfg_ready = (q_fb == r_tc);
            if (!en) w_state_nxt = HOLD;
         end
         default: w_state_nxt = CLEAR;
      endcase
      if (restart) w_state_nxt = CLEAR;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= CLEAR;
         r_tc    <= c_tc_default;
         r_exp   <= '0;
         div_o   <= 1'b0;
         tc_o    <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // In RUN, ready only at terminal count, so a new ratio lands on the wrap
         if (cfg_valid && cfg_ready)
            r_tc <= (cfg_n == '0) ? c_one : cfg_n;
         if ((r_state != CLEAR) && (q_fb != r_exp))
            err_o <= 1'b1;
         case (r_state)
            CLEAR: begin
               r_exp <= '0;
               div_o <= 1'b0;
               tc_o  <= 1'b0;
            end
            RUN: begin
               r_exp <= w_nxt;
               div_o <= (w_nxt <= (r_tc >> 1));
               tc_o  <= (w_nxt == r_tc);
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jk_div_sequencer.sv
`default_nettype none
// tb_jk_div_sequencer : randomized scoreboard bench with a behavioural J-K bank
// and an arithmetic modulo-N counter reference model.
module tb_jk_div_sequencer;
   localparam int W         = 3;
   localparam int N_DEFAULT = 3;
   localparam int M_CLEAR   = 0;
   localparam int M_HOLD    = 1;
   localparam int M_RUN     = 2;

   logic         clk       = 1'b0;
   logic         clr_n     = 1'b0;
   logic         en        = 1'b0;
   logic         restart   = 1'b0;
   logic         cfg_valid = 1'b0;
   logic [W-1:0] cfg_n     = '0;
   logic [W-1:0] stuck     = '0;
   logic [W-1:0] bank      = '0;
   logic [W-1:0] q_fb;
   logic [W-1:0] j_o, k_o;
   logic         cfg_ready, ff_clr_n, div_o, tc_o, err_o;

   always #5 clk = ~clk;

   assign q_fb = bank & ~stuck;

   jk_div_sequencer #(.W(W), .N_DEFAULT(N_DEFAULT)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .en        (en),
      .restart   (restart),
      .cfg_valid (cfg_valid),
      .cfg_n     (cfg_n),
      .cfg_ready (cfg_ready),
      .q_fb      (q_fb),
      .j_o       (j_o),
      .k_o       (k_o),
      .ff_clr_n  (ff_clr_n),
      .div_o     (div_o),
      .tc_o      (tc_o),
      .err_o     (err_o)
   );

   // 74LS112-style bank: J/K = hold, reset, set, toggle; asynchronous clear
   always @(posedge clk or negedge ff_clr_n) begin
      if (!ff_clr_n) bank <= '0;
      else begin
         for (int i = 0; i < W; i++) begin
            case ({j_o[i], k_o[i]})
               2'b01:   bank[i] <= 1'b0;
               2'b10:   bank[i] <= 1'b1;
               2'b11:   bank[i] <= ~bank[i];
               default: ;
            endcase
         end
      end
   end

   typedef struct {
      bit full;
      int q;
      bit dv, tc, ready, ffc, run, err;
   } exp_t;

   exp_t sbq[$];

   int m_mode = M_CLEAR;
   int m_cnt  = 0;
   int m_n    = N_DEFAULT;
   bit m_div  = 0;
   bit m_tc   = 0;
   bit m_err  = 0;
   bit m_gone = 0;

   task automatic push_exp();
      exp_t e;
      e.full  = !m_gone;
      e.q     = m_cnt;
      e.dv    = m_div;
      e.tc    = m_tc;
      e.ready = (m_mode == M_HOLD) || (m_mode == M_RUN && m_cnt == m_n - 1);
      e.ffc   = (m_mode != M_CLEAR);
      e.run   = (m_mode == M_RUN);
      e.err   = m_err;
      sbq.push_back(e);
   endtask

   // Reference: an integer count modulo m_n, high for the first ceil(N/2) counts
   always @(posedge clk or negedge clr_n) begin
      bit take;
      int nc;
      if (!clr_n) begin
         m_mode = M_CLEAR; m_cnt = 0; m_n = N_DEFAULT;
         m_div = 0; m_tc = 0; m_err = 0; m_gone = 0;
         sbq.delete();
         push_exp();
      end else begin
         take = cfg_valid && ((m_mode == M_HOLD) || (m_mode == M_RUN && m_cnt == m_n - 1));
         if (m_mode != M_CLEAR && !m_gone && ((m_cnt & ~int'(stuck)) != m_cnt)) begin
            m_err  = 1;
            m_gone = 1;
         end
         if (m_mode == M_RUN) begin
            nc    = (m_cnt >= m_n - 1) ? 0 : m_cnt + 1;
            m_cnt = nc;
            m_div = (nc < (m_n + 1) / 2);
            m_tc  = (nc == m_n - 1);
         end else if (m_mode == M_CLEAR) begin
            m_cnt = 0; m_div = 0; m_tc = 0;
         end
         if (take) m_n = (cfg_n == 0) ? 2 : int'(cfg_n) + 1;
         if (restart)                      m_mode = M_CLEAR;
         else if (m_mode == M_CLEAR)       m_mode = M_HOLD;
         else if (m_mode == M_HOLD && en)  m_mode = M_RUN;
         else if (m_mode == M_RUN && !en)  m_mode = M_HOLD;
         if (m_mode == M_CLEAR) m_cnt = 0;
         push_exp();
      end
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("err_o", int'(err_o), int'(e.err));
         check("ff_clr_n", int'(ff_clr_n), int'(e.ffc));
         check("jk_overlap", int'(j_o & k_o), 0);
         if (!e.run) check("jk_idle", int'({j_o, k_o}), 0);
         if (e.full && stuck == '0) begin
            check("q_fb", int'(q_fb), e.q);
            check("div_o", int'(div_o), int'(e.dv));
            check("tc_o", int'(tc_o), int'(e.tc));
            check("cfg_ready", int'(cfg_ready), int'(e.ready));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_take();
      int t = 0;
      while (!cfg_ready && t < 40) begin step(); t++; end
      if (t >= 40) begin
         n_chk++;
         $display("FAIL cfg_handshake: got no cfg_ready, expected one within 40 cycles");
      end
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_q(input int v);
      int t = 0;
      while (int'(q_fb) != v && t < 40) begin step(); t++; end
      if (t >= 40) begin
         n_chk++;
         $display("FAIL wait_q: got q_fb %0d, expected %0d within 40 cycles", q_fb, v);
      end
   endtask

   initial begin
      repeat (2) step();
      clr_n = 1'b1;
      en    = 1'b1;
      repeat (12) step();
      // ratio change offered from count 0, lands on the wrap
      wait_q(0);
      cfg_n = 3'd4; cfg_valid = 1'b1;
      wait_take();
      repeat (14) step();
      // divide-by-2 via cfg_n=0 accepted in HOLD
      en = 1'b0;
      repeat (2) step();
      cfg_n = 3'd0; cfg_valid = 1'b1;
      wait_take();
      en = 1'b1;
      repeat (10) step();
      // back to N=3, then drop en at q=1
      cfg_n = 3'd2; cfg_valid = 1'b1;
      wait_take();
      repeat (3) step();
      wait_q(1);
      en = 1'b0;
      repeat (4) step();
      en = 1'b1;
      repeat (8) step();
      // stuck-at-0 on feedback bit 0, then asynchronous reset mid-cycle
      stuck = 3'b001;
      repeat (8) step();
      #1;
      clr_n = 1'b0;
      stuck = '0;
      repeat (2) step();
      clr_n = 1'b1;
      repeat (8) step();
      // restart at terminal count together with a ratio handshake
      wait_q(2);
      cfg_n = 3'd5; cfg_valid = 1'b1; restart = 1'b1;
      step();
      cfg_valid = 1'b0; restart = 1'b0;
      repeat (20) step();
      for (int i = 0; i < 400; i++) begin
         en        = ($urandom_range(0, 9) != 0);
         restart   = ($urandom_range(0, 29) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_n     = W'($urandom);
         step();
      end
      en = 1'b0; restart = 1'b0; cfg_valid = 1'b0;
      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jk_div_sequencer.md
# jk_div_sequencer

Sequencer for a bank of W 74LS112-style J-K flip-flops forming a programmable modulo-N counter (divide-by-N, the divide-by-3 circuit being the default). It drives every stage's J, K and clear from the flip-flops' Q feedback, accepts ratio changes only at period boundaries through a valid/ready handshake, and emits a divided clock and a terminal-count strobe. It also shadows the expected count and flags any flip-flop misbehaviour.

## Interface
- W, 3: number of J-K stages (count width)
- N_DEFAULT, 3: divide ratio after reset; legal range 2..2^W
- clk  in  1  clock, shared with the J-K bank
- clr_n  in  1  asynchronous, active-low reset
- en  in  1  run enable, sampled each rising edge
- restart  in  1  synchronous request to clear the bank and return to HOLD
- cfg_valid  in  1  new ratio offered
- cfg_n  in  W  new terminal count (N-1); 0 is treated as 1
- cfg_ready  out  1  ratio change can be taken this cycle
- q_fb  in  W  Q outputs of the J-K bank, bit i = stage i
- j_o  out  W  J drive, bit i to stage i
- k_o  out  W  K drive, bit i to stage i
- ff_clr_n  out  1  active-low clear to every stage's clr_n
- div_o  out  1  divided clock, registered
- tc_o  out  1  one-cycle strobe while the bank holds the terminal count, registered
- err_o  out  1  sticky feedback-mismatch flag

## Operation
- FSM states: CLEAR, HOLD, RUN. Reset enters CLEAR.
- CLEAR
  - ff_clr_n=0, j_o=k_o=0, exp<=0, div_o<=0, tc_o<=0.
  - Next state is always HOLD.
- HOLD
  - j_o=k_o=0, so the bank keeps its state; exp, div_o and tc_o hold.
  - en=1 moves to RUN at the next edge.
- RUN
  - nxt = (q_fb >= tc_reg) ? 0 : q_fb+1, computed at W bits.
  - Drive per bit i: j_o[i] = nxt[i] & ~q_fb[i], k_o[i] = ~nxt[i] & q_fb[i]. No stage ever gets J=K=1.
  - Registered updates each edge: exp<=nxt, div_o <= (nxt <= tc_reg>>1), tc_o <= (nxt == tc_reg).
  - en=0 moves to HOLD at the next edge; the bank still advances on that edge.
- j_o, k_o, ff_clr_n and cfg_ready are combinational from the state, q_fb and tc_reg only.
- restart=1 moves any state to CLEAR at the next edge and overrides en.
- cfg_ready = (state==HOLD) | (state==RUN & q_fb==tc_reg).
- On a cfg_valid&cfg_ready edge, tc_reg <= (cfg_n==0 ? 1 : cfg_n). In RUN this is the wrap edge, so the bank goes to 0 and the next period uses the new ratio; no period mixes two ratios.
- A handshake in the same cycle as restart or an en drop is still accepted.
- Self-check: in HOLD and RUN, if q_fb != exp at a rising edge, err_o <= 1. err_o is cleared only by clr_n. No compare is made in CLEAR.
- Duty cycle: div_o is high for ceil(N/2) of every N counts (N=3: 2 high, 1 low).

## Timing
- Reset values: state=CLEAR, tc_reg=N_DEFAULT-1, exp=0, div_o=0, tc_o=0, err_o=0. This gives ff_clr_n=0, j_o=k_o=0, cfg_ready=0.
- After clr_n rises:
  - edge 1: CLEAR to HOLD.
  - edge 2: HOLD to RUN, if en=1.
  - edge 3: first count; q_fb=1, div_o=1.
- div_o and tc_o change on the same edge as the bank's Q, with zero added latency relative to the count.
- tc_o is high exactly one cycle per period; for N=2 it toggles every cycle (high while q=1).
- Ratio-change latency: takes effect at the first wrap edge where cfg_valid is high.
- Reset mid-operation: everything returns to reset values asynchronously, and the bank clears through ff_clr_n at once.

## Test plan
- Reset, en=1, N_DEFAULT=3 -> q_fb sequence 0,1,2,0,1,2; div_o 1,1,0 repeating; tc_o high only at q=2; err_o=0.
- In RUN at N=3, hold cfg_valid=1 with cfg_n=4 from count 0 -> cfg_ready high only at q=2; then sequence 0..4 (N=5), div_o high 3 of 5 counts.
- cfg_n=0 accepted in HOLD -> divide-by-2: q 0,1,0,1; div_o 1,0; tc_o high at q=1.
- Drop en at q=1 (N=3) -> bank advances to 2, then holds at 2 with j_o=k_o=0; re-raise en -> 0,1,2 resumes; err_o stays 0.
- Force q_fb bit 0 stuck at 0 during RUN -> err_o rises at the first edge where exp != q_fb and stays high until clr_n.
- Pulse restart at q=2 together with a cfg handshake -> one CLEAR cycle (ff_clr_n=0, q=0), then HOLD; new tc_reg is in effect; drop clr_n mid-count -> all outputs return to reset values immediately.
